mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Moore-FSM control unit for the multicycle MIPS datapath (shared ALU, single unified memory, IR/A/B/ALUOut regs).
//  Sequences fetch/decode/execute for lw, sw, R-type (add/sub/and/or/slt), beq, addi, j; stalls memory states on mem_ready.
//  Sits beside the datapath; replaces the single-cycle control path.
// PARAMETERS
//  USE_MEMRDY  1  1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-high
//  op         in   6  instr[31:26] from IR
//  funct      in   6  instr[5:0] from IR
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory access completes this cycle
//  mem_req    out  1  memory access in progress (FETCH, MEMRD, MEMWR)
//  iord       out  1  memory address mux: 0=PC, 1=ALUOut
//  memwrite   out  1  memory write strobe
//  irwrite    out  1  IR load enable
//  memtoreg   out  1  regfile wdata: 0=ALUOut, 1=Data reg
//  regdst     out  1  regfile waddr: 0=rt, 1=rd
//  regwrite   out  1  regfile write enable
//  alusrca    out  1  ALU A: 0=PC, 1=A reg
//  alusrcb    out  2  ALU B: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//  alucontrol out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  pcsrc      out  2  PC mux: 00=ALUResult, 01=ALUOut, 10=jump target
//  pcen       out  1  PC load enable = pcwrite | (branch & zero)
//  illegal    out  1  one-cycle pulse: unsupported op/funct decoded
// BEHAVIOUR
//  State reg async-reset to FETCH. Outputs decoded from state (+zero, mem_ready); unlisted outputs 0.
//  While reset=1: memwrite, irwrite, regwrite, pcen, illegal forced 0; all other outputs = FETCH decode.
//  rdy = mem_ready | ~USE_MEMRDY.
//  FETCH  : mem_req, alusrcb=01, alu add; irwrite=pcwrite=rdy; ->DECODE if rdy else stay.
//  DECODE : alusrcb=11, alu add (branch target into ALUOut). Next by op:
//           100011/101011->MEMADR; 000000->RTYPEEX; 000100->BEQEX; 001000->ADDIEX; 000010->JEX;
//           other op -> FETCH with illegal=1.
//  MEMADR : alusrca=1, alusrcb=10, add; lw->MEMRD, sw->MEMWR.
//  MEMRD  : mem_req, iord=1; ->MEMWB if rdy else stay.
//  MEMWB  : regdst=0, memtoreg=1, regwrite=1; ->FETCH.
//  MEMWR  : mem_req, iord=1, memwrite=1 (held while waiting); ->FETCH if rdy.
//  RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct; unsupported funct -> FETCH, illegal=1, no RTYPEWB.
//  RTYPEWB: regdst=1, memtoreg=0, regwrite=1; ->FETCH.
//  BEQEX  : alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01; pcen=zero; ->FETCH.
//  ADDIEX : alusrca=1, alusrcb=10, add; ->ADDIWB.
//  ADDIWB : regdst=0, memtoreg=0, regwrite=1; ->FETCH.
//  JEX    : pcsrc=10, pcwrite=1; ->FETCH.
//  funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
//  Zero-wait CPI: lw 5, sw 4, R 4, addi 4, beq 3, j 3; each rdy=0 cycle in a mem state adds 1.
//  Unreachable state encodings -> FETCH next cycle, all enables 0.
//  op/funct sampled only in DECODE/MEMADR/RTYPEEX (IR stable there).
//  Reset mid-instruction: immediate return to FETCH, no partial write (regwrite/memwrite drop async).
// TESTING
//  T1 reset=1 mid-MEMWR -> memwrite=0 at once; release -> FETCH, irwrite=pcen=1 first edge with mem_ready=1.
//  T2 lw (op 100011), mem_ready=1 -> states F,D,MA,MR,MWB; regwrite=1,memtoreg=1 in cycle 5 only.
//  T3 R add (funct 100000) then slt (101010) -> alucontrol 010 / 111 in RTYPEEX; regdst=1 in RTYPEWB.
//  T4 beq zero=1 -> pcen=1,pcsrc=01 in BEQEX; zero=0 -> pcen=0; both return to FETCH after 3 cycles.
//  T5 sw with mem_ready low 3 cycles in MEMWR -> memwrite held 4 cycles, then FETCH; USE_MEMRDY=0 -> 1 cycle.
//  T6 op 111111 -> illegal=1 one cycle in DECODE, next FETCH; R funct 000000 -> illegal in RTYPEEX, no regwrite.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: fetch/decode/execute for lw, sw, R-type, beq, addi, j.
// Latency: Moore outputs from state (pcen also uses zero, FETCH enables use mem_ready); lw 5, sw/R/addi 4, beq/j 3 cycles.
// Backpressure: FETCH/MEMRD/MEMWR hold while mem_ready=0 (when USE_MEMRDY=1); memwrite stays asserted while held.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   op, funct         opcode / function fields from IR
//   zero              ALU zero flag (beq)
//   mem_ready         memory access completes this cycle
//   mem_req..illegal  datapath control: memory, IR, regfile, ALU muxes, PC, illegal-instruction pulse
module mc_controller #(
    parameter bit USE_MEMRDY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     r_state;
    state_t     w_next;
    logic       w_rdy;
    logic       w_mem_req, w_iord, w_memwrite, w_irwrite, w_memtoreg, w_regdst;
    logic       w_regwrite, w_alusrca, w_pcwrite, w_branch, w_illegal;
    logic [1:0] w_alusrcb, w_pcsrc;
    logic [2:0] w_alucontrol;

    assign w_rdy = mem_ready | ~USE_MEMRDY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = S_FETCH;
        w_mem_req    = 1'b0;
        w_iord       = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_memtoreg   = 1'b0;
        w_regdst     = 1'b0;
        w_regwrite   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_alucontrol = 3'b000;
        w_pcsrc      = 2'b00;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alusrcb    = 2'b01;
                w_alucontrol = ALU_ADD;
                w_irwrite    = w_rdy;
                w_pcwrite    = w_rdy;
                w_next       = w_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // PC+4 + (SignImm<<2) lands in ALUOut as the branch target
                w_alusrcb    = 2'b11;
                w_alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_alucontrol = ALU_ADD;
                w_next       = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_next    = w_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req  = 1'b1;
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = w_rdy ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                w_alusrca = 1'b1;
                w_next    = S_RTYPEWB;
                case (funct)
                    6'b100000: w_alucontrol = ALU_ADD;
                    6'b100010: w_alucontrol = ALU_SUB;
                    6'b100100: w_alucontrol = ALU_AND;
                    6'b100101: w_alucontrol = ALU_OR;
                    6'b101010: w_alucontrol = ALU_SLT;
                    default: begin
                        // skip writeback so an unknown funct never touches the regfile
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_RTYPEWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BEQEX: begin
                w_alusrca    = 1'b1;
                w_alucontrol = ALU_SUB;
                w_branch     = 1'b1;
                w_pcsrc      = 2'b01;
            end
            S_ADDIEX: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_alucontrol = ALU_ADD;
                w_next       = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
            end
            S_JEX: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset acts on the outputs combinationally so an in-flight write is
    // cancelled immediately, not at the next edge.
    always_comb begin
        if (reset) begin
            mem_req    = 1'b1;
            iord       = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            memtoreg   = 1'b0;
            regdst     = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b01;
            alucontrol = ALU_ADD;
            pcsrc      = 2'b00;
            pcen       = 1'b0;
            illegal    = 1'b0;
        end else begin
            mem_req    = w_mem_req;
            iord       = w_iord;
            memwrite   = w_memwrite;
            irwrite    = w_irwrite;
            memtoreg   = w_memtoreg;
            regdst     = w_regdst;
            regwrite   = w_regwrite;
            alusrca    = w_alusrca;
            alusrcb    = w_alusrcb;
            alucontrol = w_alucontrol;
            pcsrc      = w_pcsrc;
            pcen       = w_pcwrite | (w_branch & zero);
            illegal    = w_illegal;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       a_mem_req, a_iord, a_memwrite, a_irwrite, a_memtoreg, a_regdst, a_regwrite, a_alusrca, a_pcen, a_illegal;
    logic [1:0] a_alusrcb, a_pcsrc;
    logic [2:0] a_alucontrol;
    logic       b_mem_req, b_iord, b_memwrite, b_irwrite, b_memtoreg, b_regdst, b_regwrite, b_alusrca, b_pcen, b_illegal;
    logic [1:0] b_alusrcb, b_pcsrc;
    logic [2:0] b_alucontrol;

    int checks = 0;
    int errors = 0;
    int memwrite_cycles;

    // word layout: mem_req iord memwrite irwrite memtoreg regdst regwrite alusrca alusrcb[2] alucontrol[3] pcsrc[2] pcen illegal
    logic [16:0] word_a, word_b;
    assign word_a = {a_mem_req, a_iord, a_memwrite, a_irwrite, a_memtoreg, a_regdst, a_regwrite, a_alusrca,
                     a_alusrcb, a_alucontrol, a_pcsrc, a_pcen, a_illegal};
    assign word_b = {b_mem_req, b_iord, b_memwrite, b_irwrite, b_memtoreg, b_regdst, b_regwrite, b_alusrca,
                     b_alusrcb, b_alucontrol, b_pcsrc, b_pcen, b_illegal};

    localparam logic [16:0] STALL_MASK = 17'h1DFFD; // clears irwrite (bit 13) and pcen (bit 1)

    mc_controller #(.USE_MEMRDY(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .iord(a_iord), .memwrite(a_memwrite), .irwrite(a_irwrite),
        .memtoreg(a_memtoreg), .regdst(a_regdst), .regwrite(a_regwrite), .alusrca(a_alusrca),
        .alusrcb(a_alusrcb), .alucontrol(a_alucontrol), .pcsrc(a_pcsrc), .pcen(a_pcen), .illegal(a_illegal)
    );

    mc_controller #(.USE_MEMRDY(1'b0)) dut_nordy (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite),
        .memtoreg(b_memtoreg), .regdst(b_regdst), .regwrite(b_regwrite), .alusrca(b_alusrca),
        .alusrcb(b_alusrcb), .alucontrol(b_alucontrol), .pcsrc(b_pcsrc), .pcen(b_pcen), .illegal(b_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] cw(input logic mreq, iord, mw, irw, m2r, rd, rw, sa,
                                       input logic [1:0] sb, input logic [2:0] ac,
                                       input logic [1:0] ps, input logic pe, il);
        return {mreq, iord, mw, irw, m2r, rd, rw, sa, sb, ac, ps, pe, il};
    endfunction

    // Reference model: the per-cycle control words an instruction should produce,
    // plus which of those cycles are memory accesses that wait for mem_ready.
    logic [16:0] plan_w[$];
    bit          plan_m[$];

    function automatic logic [16:0] reset_word();
        return cw(1,0,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0, 0);
    endfunction

    task automatic build_plan(input logic [5:0] o, input logic [5:0] f, input logic z);
        logic [2:0] ac;
        bit         ok;
        plan_w.delete(); plan_m.delete();
        plan_w.push_back(cw(1,0,0,1,0,0,0,0, 2'b01, 3'b010, 2'b00, 1, 0)); plan_m.push_back(1);
        ok = 1;
        case (o)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: ok = 1;
            default: ok = 0;
        endcase
        plan_w.push_back(cw(0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0, !ok)); plan_m.push_back(0);
        if (o == 6'b100011) begin
            plan_w.push_back(cw(0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0)); plan_m.push_back(0);
            plan_w.push_back(cw(1,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0, 0)); plan_m.push_back(1);
            plan_w.push_back(cw(0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 0, 0)); plan_m.push_back(0);
        end else if (o == 6'b101011) begin
            plan_w.push_back(cw(0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0)); plan_m.push_back(0);
            plan_w.push_back(cw(1,1,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0, 0)); plan_m.push_back(1);
        end else if (o == 6'b000000) begin
            ok = 1;
            case (f)
                6'b100000: ac = 3'b010;
                6'b100010: ac = 3'b110;
                6'b100100: ac = 3'b000;
                6'b100101: ac = 3'b001;
                6'b101010: ac = 3'b111;
                default: begin ac = 3'b000; ok = 0; end
            endcase
            plan_w.push_back(cw(0,0,0,0,0,0,0,1, 2'b00, ac, 2'b00, 0, !ok)); plan_m.push_back(0);
            if (ok) begin
                plan_w.push_back(cw(0,0,0,0,0,1,1,0, 2'b00, 3'b000, 2'b00, 0, 0)); plan_m.push_back(0);
            end
        end else if (o == 6'b000100) begin
            plan_w.push_back(cw(0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, z, 0)); plan_m.push_back(0);
        end else if (o == 6'b001000) begin
            plan_w.push_back(cw(0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0)); plan_m.push_back(0);
            plan_w.push_back(cw(0,0,0,0,0,0,1,0, 2'b00, 3'b000, 2'b00, 0, 0)); plan_m.push_back(0);
        end else if (o == 6'b000010) begin
            plan_w.push_back(cw(0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 1, 0)); plan_m.push_back(0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH back to the next FETCH, checking every cycle.
    // wmode: 0 always ready, 1 random stalls, 2 exactly three stalls on non-FETCH memory steps.
    // use_b selects the USE_MEMRDY=0 instance, whose memory steps never stall.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int wmode, input bit use_b);
        logic [16:0] exp_w, got;
        int          waits;
        bit          rdy;
        build_plan(o, f, z);
        op = o; funct = f; zero = z;
        memwrite_cycles = 0;
        for (int s = 0; s < plan_w.size(); s++) begin
            waits = 0;
            forever begin
                if (!plan_m[s]) mem_ready = 1'($urandom_range(1));
                else if (wmode == 1) mem_ready = (waits < 5) ? ($urandom_range(3) != 0) : 1'b1;
                else if (wmode == 2 && s > 0) mem_ready = (waits >= 3);
                else mem_ready = 1'b1;
                rdy = !plan_m[s] || use_b || mem_ready;
                exp_w = rdy ? plan_w[s] : (plan_w[s] & STALL_MASK);
                @(negedge clk);
                got = use_b ? word_b : word_a;
                if (got[14]) memwrite_cycles++;
                checks++;
                if (got !== exp_w) begin
                    errors++;
                    $display("FAIL %s step %0d wait %0d: got %05h expected %05h", name, s, waits, got, exp_w);
                end
                @(posedge clk); #1;
                if (rdy) break;
                waits++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if (word_a !== reset_word()) begin
            errors++; $display("FAIL reset_outputs: got %05h expected %05h", word_a, reset_word());
        end
        do_reset();
        run_instr("post_reset_j", 6'b000010, 6'd0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_midwrite();
        do_reset();
        op = 6'b101011; funct = 6'd0; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (a_memwrite !== 1'b1) begin errors++; $display("FAIL midwrite_pre: memwrite got %b expected 1", a_memwrite); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (word_a !== reset_word()) begin
            errors++; $display("FAIL midwrite_async: got %05h expected %05h", word_a, reset_word());
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_irwrite, a_pcen, a_mem_req} !== 3'b111) begin
            errors++; $display("FAIL midwrite_release: irwrite/pcen/mem_req got %b expected 111", {a_irwrite, a_pcen, a_mem_req});
        end
        do_reset();
    endtask

    task automatic test_lw();
        do_reset();
        run_instr("lw", 6'b100011, 6'h15, 1'b0, 0, 0);
        run_instr("lw_follow_j", 6'b000010, 6'd0, 1'b1, 0, 0);
    endtask

    task automatic test_rtype();
        do_reset();
        run_instr("r_add", 6'b000000, 6'b100000, 1'b0, 0, 0);
        run_instr("r_slt", 6'b000000, 6'b101010, 1'b1, 0, 0);
        run_instr("r_sub", 6'b000000, 6'b100010, 1'b0, 0, 0);
        run_instr("r_and", 6'b000000, 6'b100100, 1'b0, 0, 0);
        run_instr("r_or",  6'b000000, 6'b100101, 1'b0, 0, 0);
    endtask

    task automatic test_beq();
        do_reset();
        run_instr("beq_taken", 6'b000100, 6'd0, 1'b1, 0, 0);
        run_instr("beq_not",   6'b000100, 6'd0, 1'b0, 0, 0);
        run_instr("addi",      6'b001000, 6'd0, 1'b1, 0, 0);
    endtask

    task automatic test_sw_stall();
        do_reset();
        run_instr("sw_stall", 6'b101011, 6'd0, 1'b0, 2, 0);
        checks++;
        if (memwrite_cycles != 4) begin
            errors++; $display("FAIL sw_stall_len: memwrite cycles got %0d expected 4", memwrite_cycles);
        end
        run_instr("sw_stall_next", 6'b000010, 6'd0, 1'b0, 0, 0);
        do_reset();
        run_instr("sw_nordy", 6'b101011, 6'd0, 1'b0, 2, 1);
        checks++;
        if (memwrite_cycles != 1) begin
            errors++; $display("FAIL sw_nordy_len: memwrite cycles got %0d expected 1", memwrite_cycles);
        end
        run_instr("nordy_lw", 6'b100011, 6'd0, 1'b0, 1, 1);
    endtask

    task automatic test_illegal();
        logic [5:0] bad;
        do_reset();
        run_instr("illegal_op", 6'b111111, 6'd0, 1'b0, 0, 0);
        run_instr("illegal_funct", 6'b000000, 6'b000000, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bad = 6'($urandom_range(63));
            if (bad == 6'b100011 || bad == 6'b101011 || bad == 6'b000000 ||
                bad == 6'b000100 || bad == 6'b001000 || bad == 6'b000010) bad = 6'b110011;
            run_instr("illegal_rand", bad, 6'($urandom_range(63)), 1'b0, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[7];
        logic [5:0] fns[6];
        logic [5:0] o, f;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000};
        do_reset();
        for (int i = 0; i < 60; i++) begin
            o = ops[$urandom_range(6)];
            f = fns[$urandom_range(5)];
            if ($urandom_range(15) == 0) o = 6'b010001;
            run_instr("random", o, f, 1'($urandom_range(1)), 1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_reset_midwrite();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_stall();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
